// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default counter width, weak init
// values and the saturating direction-counter update used by fetch and update.
package bp_pkg;

    localparam int BP_CWIDTH = 2;
    localparam logic [BP_CWIDTH-1:0] BP_WEAK_TAKEN     = 2'b10;
    localparam logic [BP_CWIDTH-1:0] BP_WEAK_NOT_TAKEN = 2'b01;

    // Works on a 32-bit container so any counter width up to 31 can share it.
    function automatic logic [31:0] bp_sat_update(input logic [31:0] cur,
                                                  input logic        hit,
                                                  input logic        taken,
                                                  input int          cwidth);
        logic [31:0] max_val;
        logic [31:0] weak_t;
        max_val = (32'd1 << cwidth) - 32'd1;
        weak_t  = 32'd1 << (cwidth - 1);
        if (!hit)
            return taken ? weak_t : weak_t - 32'd1;
        if (taken)
            return (cur >= max_val) ? max_val : cur + 32'd1;
        return (cur == 32'd0) ? 32'd0 : cur - 32'd1;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO holding resolved-branch updates; the head entry is
// readable combinationally so the top can look it up in the same cycle.
module bp_update_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/bp_update_unit.sv
// Queues resolved branches and read-modify-writes their direction counters
// through the cache's second read port and write port; keeps CSR statistics.
module bp_update_unit
    import bp_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int CWIDTH = BP_CWIDTH,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [AWIDTH-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_pred_taken,
    output logic [AWIDTH-1:0] rd_addr,
    input  logic [CWIDTH-1:0] rd_data,
    input  logic              rd_hit,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [CWIDTH-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic [31:0]       update_count,
    output logic [31:0]       mispredict_count
);

    localparam int EW = AWIDTH + 2;

    logic [EW-1:0]     head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [AWIDTH-1:0] head_pc;
    logic              head_taken;
    logic              head_pred;
    logic              fwd;
    logic [CWIDTH-1:0] cur;
    logic              cur_hit;
    logic [CWIDTH-1:0] new_ctr;

    assign upd_ready = !full && !flush && !reset;
    assign push      = upd_valid && upd_ready;
    assign pop       = !empty && !flush;
    assign busy      = !empty || wr_en;

    bp_update_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .clear(flush),
        .push (push),
        .din  ({upd_pc, upd_taken, upd_pred_taken}),
        .pop  (pop),
        .head (head),
        .full (full),
        .empty(empty)
    );

    assign {head_pc, head_taken, head_pred} = head;
    assign rd_addr = head_pc;

    // The cache has not yet absorbed the write now on wr_en, so a back-to-back
    // update of the same PC must take the counter from the write register.
    assign fwd     = wr_en && (wr_addr == head_pc);
    assign cur     = fwd ? wr_data : rd_data;
    assign cur_hit = fwd || rd_hit;
    assign new_ctr = CWIDTH'(bp_sat_update(32'(cur), cur_hit, head_taken, CWIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en            <= 1'b0;
            wr_addr          <= '0;
            wr_data          <= '0;
            update_count     <= '0;
            mispredict_count <= '0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_addr      <= head_pc;
                wr_data      <= new_ctr;
                update_count <= update_count + 32'd1;
                if (head_taken != head_pred)
                    mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bp_update_unit.sv
// Directed bench for bp_update_unit: the cache is a stub driven directly
// through rd_data/rd_hit, and expected writes are worked out by hand.
module tb_bp_update_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] rd_addr;
    logic [1:0]  rd_data;
    logic        rd_hit;
    logic [31:0] wr_addr;
    logic [1:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic [31:0] update_count;
    logic [31:0] mispredict_count;

    int check_count = 0;
    int pass_count  = 0;

    bp_update_unit #(
        .AWIDTH(32),
        .CWIDTH(2),
        .DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_pred_taken  (upd_pred_taken),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .rd_hit          (rd_hit),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_en           (wr_en),
        .busy            (busy),
        .update_count    (update_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic taken, input logic pred,
                                 input logic hit, input logic [1:0] data);
        upd_valid      = valid;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_pred_taken = pred;
        rd_hit         = hit;
        rd_data        = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        step();
        checkOutput("rst_ready", 32'(upd_ready), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", wr_addr, 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_upd_cnt", update_count, 32'd0);
        checkOutput("rst_mis_cnt", mispredict_count, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(upd_ready), 32'd1);

        // Cold miss: taken on miss initialises to weakly taken.
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 2'b00);
        step();
        upd_valid = 1'b0;
        #1;
        checkOutput("cold_rd_addr", rd_addr, 32'h100);
        checkOutput("cold_busy", 32'(busy), 32'd1);
        checkOutput("cold_wr_en_early", 32'(wr_en), 32'd0);
        step();
        checkOutput("cold_wr_en", 32'(wr_en), 32'd1);
        checkOutput("cold_wr_addr", wr_addr, 32'h100);
        checkOutput("cold_wr_data", 32'(wr_data), 32'd2);
        checkOutput("cold_upd_cnt", update_count, 32'd1);
        checkOutput("cold_mis_cnt", mispredict_count, 32'd1);

        // Saturation at the top and bottom, then a mid-range hit and a not-taken miss.
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 2'b11);
        step();
        upd_valid = 1'b0;
        checkOutput("cold_wr_en_off", 32'(wr_en), 32'd0);
        step();
        checkOutput("sat_hi_data", 32'(wr_data), 32'd3);
        checkOutput("sat_hi_addr", wr_addr, 32'h300);
        applyStimulus(1'b1, 32'h304, 1'b0, 1'b0, 1'b1, 2'b00);
        step();
        upd_valid = 1'b0;
        step();
        checkOutput("sat_lo_data", 32'(wr_data), 32'd0);
        checkOutput("sat_upd_cnt", update_count, 32'd3);
        checkOutput("sat_mis_cnt", mispredict_count, 32'd1);
        applyStimulus(1'b1, 32'h308, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        upd_valid = 1'b0;
        step();
        checkOutput("mid_hit_data", 32'(wr_data), 32'd2);
        applyStimulus(1'b1, 32'h30C, 1'b0, 1'b1, 1'b0, 2'b00);
        step();
        upd_valid = 1'b0;
        step();
        checkOutput("miss_nt_data", 32'(wr_data), 32'd1);
        checkOutput("miss_nt_upd_cnt", update_count, 32'd5);
        checkOutput("miss_nt_mis_cnt", mispredict_count, 32'd3);
        step();

        // Back-to-back same PC: the cache keeps returning a stale 01.
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 2'b01);
        step();
        step();
        upd_valid = 1'b0;
        checkOutput("fwd1_wr_en", 32'(wr_en), 32'd1);
        checkOutput("fwd1_data", 32'(wr_data), 32'd2);
        step();
        checkOutput("fwd2_wr_en", 32'(wr_en), 32'd1);
        checkOutput("fwd2_data", 32'(wr_data), 32'd3);
        checkOutput("fwd_upd_cnt", update_count, 32'd7);
        checkOutput("fwd_mis_cnt", mispredict_count, 32'd3);
        step();
        checkOutput("fwd_wr_en_off", 32'(wr_en), 32'd0);

        // Burst of 5 consecutive updates: 1/cycle drain keeps upd_ready high.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(4 * i), i[0], 1'b1, 1'b0, 2'b00);
            #1;
            checkOutput("burst_ready", 32'(upd_ready), 32'd1);
            step();
            if (i >= 1) begin
                checkOutput("burst_wr_addr", wr_addr, 32'h400 + 32'(4 * (i - 1)));
                checkOutput("burst_wr_data", 32'(wr_data), (i - 1) % 2 == 1 ? 32'd2 : 32'd1);
            end
        end
        upd_valid = 1'b0;
        step();
        checkOutput("burst_last_addr", wr_addr, 32'h410);
        checkOutput("burst_last_data", 32'(wr_data), 32'd1);
        checkOutput("burst_upd_cnt", update_count, 32'd12);
        checkOutput("burst_mis_cnt", mispredict_count, 32'd6);
        step();

        // Flush with updates queued: only the already-registered write survives.
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 2'b00);
        step();
        upd_pc = 32'h504;
        step();
        upd_pc = 32'h508;
        flush  = 1'b1;
        #1;
        checkOutput("flush_ready", 32'(upd_ready), 32'd0);
        checkOutput("flush_wr_en", 32'(wr_en), 32'd1);
        checkOutput("flush_wr_addr", wr_addr, 32'h500);
        step();
        flush     = 1'b0;
        upd_valid = 1'b0;
        checkOutput("post_flush_wr_en", 32'(wr_en), 32'd0);
        checkOutput("post_flush_upd_cnt", update_count, 32'd13);
        checkOutput("post_flush_mis_cnt", mispredict_count, 32'd7);
        checkOutput("post_flush_busy", 32'(busy), 32'd0);
        step();
        checkOutput("flush_settle_upd_cnt", update_count, 32'd13);
        checkOutput("flush_settle_wr_en", 32'(wr_en), 32'd0);

        // Reset in the middle of a stream drops the write and the statistics.
        applyStimulus(1'b1, 32'h600, 1'b1, 1'b0, 1'b1, 2'b01);
        step();
        upd_pc = 32'h604;
        step();
        checkOutput("pre_rst_wr_en", 32'(wr_en), 32'd1);
        reset = 1'b1;
        step();
        upd_valid = 1'b0;
        checkOutput("mid_rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("mid_rst_upd_cnt", update_count, 32'd0);
        checkOutput("mid_rst_mis_cnt", mispredict_count, 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_ready", 32'(upd_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("after_rst_ready", 32'(upd_ready), 32'd1);
        step();
        checkOutput("after_rst_wr_en", 32'(wr_en), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
